spike_train_decoder: RTL and testbench

Receive-side companion to the Izhikevich neuron tile. It consumes the neuron's spike output and turns it back into numbers: a spike count (rate) per programmable window, plus inter-spike-interval (ISI) statistics. Each window's results go out through a valid/ready handshake to the readout logic.

---
 rtl/spike_train_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_spike_train_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_train_decoder.sv
// Spike train decoder: per-window spike rate and inter-spike-interval statistics, published via valid/ready.
// Optional burst detection is compiled in when SPIKE_BURST_DETECT_EN is defined.
module spike_train_decoder #(
    parameter int WIN_W     = 12,
    parameter int CNT_W     = 8,
    parameter int ISI_W     = 12,
    parameter int BURST_ISI = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] isi_min_out,
    output logic [ISI_W-1:0] isi_last_out,
    output logic             burst_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_ZERO = {ISI_W{1'b0}};
    localparam logic [ISI_W-1:0] ISI_ONE  = {{(ISI_W-1){1'b0}}, 1'b1};
    localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

    state_t           state_r, state_s;
    logic             spike_q_r, spike_q_s;
    logic [WIN_W-1:0] win_len_q_r, win_len_q_s;
    logic [WIN_W-1:0] win_cnt_r, win_cnt_s;
    logic [CNT_W-1:0] spike_cnt_r, spike_cnt_s;
    logic [ISI_W-1:0] isi_min_w_r, isi_min_w_s;
    logic [ISI_W-1:0] isi_cnt_r, isi_cnt_s;
    logic             first_seen_r, first_seen_s;
    logic [CNT_W-1:0] rate_s;
    logic [ISI_W-1:0] isi_min_pub_s;
    logic [ISI_W-1:0] isi_last_s;
    logic             out_valid_s;
    logic             overrun_s;
    logic             spike_det_s;
    logic             close_s;
    logic             isi_hit_s;

`ifdef SPIKE_BURST_DETECT_EN
    localparam logic [ISI_W-1:0] BURST_LIM = ISI_W'(BURST_ISI);
    logic [1:0] run_r, run_s;
    logic       flag_r, flag_s;
    logic       burst_pub_s;
`endif

    assign spike_det_s = spike_in & ~spike_q_r;
    assign close_s     = (win_cnt_r == (win_len_q_r - WIN_ONE));
    assign isi_hit_s   = spike_det_s & first_seen_r;

    // Next-state and result computation for the window FSM and ISI tracker.
    always_comb begin
        state_s       = state_r;
        spike_q_s     = spike_q_r;
        win_len_q_s   = win_len_q_r;
        win_cnt_s     = win_cnt_r;
        spike_cnt_s   = spike_cnt_r;
        isi_min_w_s   = isi_min_w_r;
        isi_cnt_s     = isi_cnt_r;
        first_seen_s  = first_seen_r;
        rate_s        = rate_out;
        isi_min_pub_s = isi_min_out;
        isi_last_s    = isi_last_out;
        overrun_s     = overrun;
`ifdef SPIKE_BURST_DETECT_EN
        run_s         = run_r;
        flag_s        = flag_r;
        burst_pub_s   = burst_out;
`endif
        // A consume this cycle is overridden below if a close publishes at the same time.
        if (out_valid && out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid;
        end

        if (ena) begin
            spike_q_s = spike_in;
            case (state_r)
                IDLE: begin
                    if (win_len != WIN_ZERO) begin
                        state_s     = RUN;
                        win_len_q_s = win_len;
                        win_cnt_s   = WIN_ZERO;
                        spike_cnt_s = CNT_ZERO;
                        isi_min_w_s = ISI_MAX;
`ifdef SPIKE_BURST_DETECT_EN
                        flag_s      = 1'b0;
`endif
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    win_cnt_s = win_cnt_r + WIN_ONE;
                    if (spike_det_s) begin
                        spike_cnt_s  = (spike_cnt_r == CNT_MAX) ? spike_cnt_r : spike_cnt_r + CNT_ONE;
                        isi_cnt_s    = ISI_ONE;
                        first_seen_s = 1'b1;
                    end else begin
                        isi_cnt_s = (isi_cnt_r == ISI_MAX) ? isi_cnt_r : isi_cnt_r + ISI_ONE;
                    end

                    if (isi_hit_s) begin
                        isi_last_s  = isi_cnt_r;
                        isi_min_w_s = (isi_cnt_r < isi_min_w_r) ? isi_cnt_r : isi_min_w_r;
`ifdef SPIKE_BURST_DETECT_EN
                        if (isi_cnt_r <= BURST_LIM) begin
                            run_s  = (run_r == 2'd2) ? 2'd2 : run_r + 2'd1;
                            flag_s = flag_r | (run_s == 2'd2);
                        end else begin
                            run_s = 2'd0;
                        end
`endif
                    end else begin
                        isi_last_s = isi_last_out;
                    end

                    // Close cycle: publish including this cycle's spike, then restart or stop.
                    if (close_s) begin
                        rate_s        = spike_cnt_s;
                        isi_min_pub_s = isi_min_w_s;
                        out_valid_s   = 1'b1;
`ifdef SPIKE_BURST_DETECT_EN
                        burst_pub_s   = flag_s;
`endif
                        if (out_valid && !out_ready) begin
                            overrun_s = 1'b1;
                        end else begin
                            overrun_s = overrun;
                        end
                        if (win_len != WIN_ZERO) begin
                            state_s     = RUN;
                            win_len_q_s = win_len;
                            win_cnt_s   = WIN_ZERO;
                            spike_cnt_s = CNT_ZERO;
                            isi_min_w_s = ISI_MAX;
`ifdef SPIKE_BURST_DETECT_EN
                            flag_s      = 1'b0;
`endif
                        end else begin
                            state_s      = IDLE;
                            first_seen_s = 1'b0;
                        end
                    end else begin
                        state_s = RUN;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            spike_q_s = spike_q_r;
        end
    end

    // State, counter and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            spike_q_r    <= 1'b0;
            win_len_q_r  <= WIN_ZERO;
            win_cnt_r    <= WIN_ZERO;
            spike_cnt_r  <= CNT_ZERO;
            isi_min_w_r  <= ISI_ZERO;
            isi_cnt_r    <= ISI_ZERO;
            first_seen_r <= 1'b0;
            rate_out     <= CNT_ZERO;
            isi_min_out  <= ISI_MAX;
            isi_last_out <= ISI_ZERO;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_r      <= state_s;
            spike_q_r    <= spike_q_s;
            win_len_q_r  <= win_len_q_s;
            win_cnt_r    <= win_cnt_s;
            spike_cnt_r  <= spike_cnt_s;
            isi_min_w_r  <= isi_min_w_s;
            isi_cnt_r    <= isi_cnt_s;
            first_seen_r <= first_seen_s;
            rate_out     <= rate_s;
            isi_min_out  <= isi_min_pub_s;
            isi_last_out <= isi_last_s;
            out_valid    <= out_valid_s;
            overrun      <= overrun_s;
        end
    end

`ifdef SPIKE_BURST_DETECT_EN
    // Burst run counter, window flag and published burst bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_r     <= 2'd0;
            flag_r    <= 1'b0;
            burst_out <= 1'b0;
        end else begin
            run_r     <= run_s;
            flag_r    <= flag_s;
            burst_out <= burst_pub_s;
        end
    end
`else
    assign burst_out = 1'b0;
`endif

endmodule

// File: tb/tb_spike_train_decoder.sv
// Self-checking bench for spike_train_decoder: directed test-plan scenarios plus randomized traffic,
// compared every cycle against an event/timestamp-level reference model.
module tb_spike_train_decoder;

    localparam int WIN_W     = 12;
    localparam int CNT_W     = 8;
    localparam int ISI_W     = 12;
    localparam int BURST_ISI = 16;
    localparam int CNT_SAT   = 255;
    localparam int ISI_SAT   = 4095;
`ifdef SPIKE_BURST_DETECT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             spike_in;
    logic [WIN_W-1:0] win_len;
    logic             out_ready;
    logic [CNT_W-1:0] rate_out;
    logic [ISI_W-1:0] isi_min_out;
    logic [ISI_W-1:0] isi_last_out;
    logic             burst_out;
    logic             out_valid;
    logic             overrun;

    spike_train_decoder #(
        .WIN_W(WIN_W), .CNT_W(CNT_W), .ISI_W(ISI_W), .BURST_ISI(BURST_ISI)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .win_len(win_len),
        .rate_out(rate_out), .isi_min_out(isi_min_out), .isi_last_out(isi_last_out),
        .burst_out(burst_out), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int valid_pulses = 0;

    // Reference model: timestamps of spikes and window position, not the RTL's counters.
    int m_t, m_last, m_wlen, m_wpos, m_count, m_min, m_run;
    bit m_running, m_first, m_spike_q, m_flag;
    int e_rate, e_min, e_last;
    bit e_burst, e_valid, e_over;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_last = 0; m_wlen = 0; m_wpos = 0; m_count = 0; m_min = ISI_SAT; m_run = 0;
        m_running = 0; m_first = 0; m_spike_q = 0; m_flag = 0;
        e_rate = 0; e_min = ISI_SAT; e_last = 0; e_burst = 0; e_valid = 0; e_over = 0;
    endtask

    task automatic model_open(input int len);
        m_wlen = len; m_wpos = 0; m_count = 0; m_min = ISI_SAT; m_flag = 0;
    endtask

    task automatic model_step();
        bit old_valid;
        bit sp;
        int isi;
        if (!rst) begin
            model_reset();
            return;
        end
        old_valid = e_valid;
        if (e_valid && out_ready) e_valid = 0;
        if (ena) begin
            sp = spike_in && !m_spike_q;
            if (!m_running) begin
                if (win_len != 0) begin
                    m_running = 1;
                    model_open(int'(win_len));
                end
            end else begin
                if (sp) begin
                    m_count++;
                    if (m_first) begin
                        isi = m_t - m_last;
                        if (isi > ISI_SAT) isi = ISI_SAT;
                        e_last = isi;
                        if (isi < m_min) m_min = isi;
                        if (isi <= BURST_ISI) m_run++; else m_run = 0;
                        if (m_run >= 2) m_flag = 1;
                    end
                    m_first = 1;
                    m_last = m_t;
                end
                m_wpos++;
                if (m_wpos == m_wlen) begin
                    if (old_valid && !out_ready) e_over = 1;
                    e_valid = 1;
                    e_rate  = (m_count > CNT_SAT) ? CNT_SAT : m_count;
                    e_min   = m_min;
                    e_burst = BURST_EN && m_flag;
                    if (win_len != 0) begin
                        model_open(int'(win_len));
                    end else begin
                        m_running = 0;
                        m_first = 0;
                    end
                end
            end
            m_spike_q = spike_in;
            m_t++;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) valid_pulses++;
        check("rate_out", 32'(rate_out), 32'(e_rate));
        check("isi_min_out", 32'(isi_min_out), 32'(e_min));
        check("isi_last_out", 32'(isi_last_out), 32'(e_last));
        check("burst_out", 32'(burst_out), 32'(e_burst));
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("overrun", 32'(overrun), 32'(e_over));
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0; ena = 1'b1; spike_in = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b1;
    endtask

    task automatic run_pattern(input int n, input int period, input int offset, input int width, input bit rdy);
        out_ready = rdy;
        for (int i = 0; i < n; i++) begin
            spike_in = (i >= offset) && (((i - offset) % period) < width);
            cycle();
        end
        spike_in = 1'b0;
    endtask

    task automatic run_list(input int n, input int times[$], input bit rdy);
        out_ready = rdy;
        for (int i = 0; i < n; i++) begin
            spike_in = 1'b0;
            foreach (times[k]) if (times[k] == i) spike_in = 1'b1;
            cycle();
        end
        spike_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b1; spike_in = 1'b0; out_ready = 1'b1; win_len = 12'd100;
        model_reset();

        // Regular 10-cycle spikes in 100-cycle windows.
        apply_reset(2);
        valid_pulses = 0;
        run_pattern(301, 10, 6, 1, 1'b1);
        check("tp1_rate", 32'(rate_out), 32'd10);
        check("tp1_isi_min", 32'(isi_min_out), 32'd10);
        check("tp1_valid_pulses", 32'(valid_pulses), 32'd3);

        // Held-high levels count once each.
        win_len = 12'd200;
        apply_reset(1);
        run_pattern(201, 70, 10, 5, 1'b1);
        check("tp2_rate", 32'(rate_out), 32'd3);

        // Rate saturation.
        win_len = 12'd1000;
        apply_reset(1);
        run_pattern(1001, 2, 1, 1, 1'b1);
        check("tp3_rate_sat", 32'(rate_out), 32'd255);
        check("tp3_isi_min", 32'(isi_min_out), 32'd2);

        // Overrun across two unconsumed closes, then consume.
        win_len = 12'd50;
        apply_reset(1);
        run_pattern(51, 13, 2, 1, 1'b0);
        check("tp4_first_rate", 32'(rate_out), 32'd4);
        run_pattern(50, 7, 1, 1, 1'b0);
        check("tp4_overrun", 32'(overrun), 32'd1);
        check("tp4_rate", 32'(rate_out), 32'd7);
        check("tp4_valid_held", 32'(out_valid), 32'd1);
        run_pattern(1, 1000, 5, 1, 1'b1);
        check("tp4_valid_fall", 32'(out_valid), 32'd0);
        check("tp4_overrun_sticky", 32'(overrun), 32'd1);

        // win_len=0 stays idle; mid-window reset discards the partial window.
        win_len = 12'd0;
        apply_reset(1);
        valid_pulses = 0;
        run_pattern(50, 5, 0, 1, 1'b1);
        check("tp5_idle_pulses", 32'(valid_pulses), 32'd0);
        win_len = 12'd100;
        run_pattern(51, 10, 3, 1, 1'b1);
        win_len = 12'd0;
        apply_reset(1);
        check("tp5_rst_rate", 32'(rate_out), 32'd0);
        check("tp5_rst_isi_min", 32'(isi_min_out), 32'd4095);
        check("tp5_rst_isi_last", 32'(isi_last_out), 32'd0);
        run_pattern(5, 2, 0, 1, 1'b1);
        check("tp5_no_result", 32'(valid_pulses), 32'd0);

        // Burst pattern 5,5,50 versus 5,50,5.
        win_len = 12'd200;
        apply_reset(1);
        run_list(201, '{10, 15, 20, 70}, 1'b1);
        check("tp6_burst_a", 32'(burst_out), 32'(BURST_EN));
        apply_reset(1);
        run_list(201, '{10, 15, 65, 70}, 1'b1);
        check("tp6_burst_b", 32'(burst_out), 32'd0);

        // Randomized traffic with enable gaps, back-pressure, window changes and resets.
        win_len = 12'd20;
        apply_reset(1);
        for (int i = 0; i < 4000; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            spike_in  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            rst       = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 4))
                    0: win_len = 12'd0;
                    1: win_len = 12'd1;
                    2: win_len = 12'($urandom_range(2, 5));
                    default: win_len = 12'($urandom_range(10, 60));
                endcase
            end
            cycle();
        end
        ena = 1'b1;

        // ISI counter saturation.
        win_len = 12'd100;
        apply_reset(1);
        run_list(4210, '{5, 4205}, 1'b1);
        check("tp7_isi_sat", 32'(isi_last_out), 32'd4095);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
